// File: rtl/calc_controller_if.sv
// calc_controller_if: keypad handshake and arithmetic-unit bus for calc_controller.
//   master : controller side (drives key_ready, V1, V2, opcode, pulses, disp, err)
//   slave  : keypad / arithmetic-unit side (drives key_valid, key_code, answer, ovw_in)
// Sign-magnitude values are 17 bits: bit 16 sign, bits 15:0 magnitude.
interface calc_controller_if;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_ready;
  logic [16:0] V1;
  logic [16:0] V2;
  logic [1:0]  opcode;
  logic        newop;
  logic        newhex;
  logic        eq;
  logic [16:0] answer;
  logic        ovw_in;
  logic [16:0] disp;
  logic        err;

  modport master (
    input  key_valid, key_code, answer, ovw_in,
    output key_ready, V1, V2, opcode, newop, newhex, eq, disp, err
  );

  modport slave (
    output key_valid, key_code, answer, ovw_in,
    input  key_ready, V1, V2, opcode, newop, newhex, eq, disp, err
  );
endinterface

// File: rtl/calc_controller.sv
// calc_controller: keypad-driven hex calculator sequencer.
// Collects hex-digit operands and operator keys, presents entry (V1) and
// accumulator (V2) to an external arithmetic unit, and captures its answer
// one cycle after the eq pulse.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high
//   bus    - calc_controller_if.master (key handshake, operands, opcode,
//            newop/newhex/eq pulses, answer/ovw_in, disp, err)
// Parameter: MAX_DIGITS - hex digits accepted per operand entry.
// Optional feature macro CALC_CHAIN_EN: an operator key during second-operand
// entry evaluates immediately and then loads that operator as the next opcode.
module calc_controller #(
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic              clock,
  input  logic              reset,
  calc_controller_if.master bus
);
  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {S_A, S_OP, S_B, S_EVAL, S_RES, S_ERR} state_t;

  state_t        r_state, w_state;
  logic [16:0]   r_entry, w_entry;
  logic [16:0]   r_acc, w_acc;
  logic [1:0]    r_opcode, w_opcode;
  logic [CW-1:0] r_count, w_count;
  logic          r_newop, w_newop;
  logic          r_newhex, w_newhex;
  logic          r_eq, w_eq;
`ifdef CALC_CHAIN_EN
  logic [1:0]    r_pend, w_pend;
  logic          r_chain, w_chain;
`endif

  logic w_digit, w_oper, w_equals, w_clear, w_neg, w_room;
  assign w_digit  = bus.key_valid && !bus.key_code[4];
  assign w_oper   = bus.key_valid && (bus.key_code inside {5'd16, 5'd17, 5'd18});
  assign w_equals = bus.key_valid && (bus.key_code == 5'd19);
  assign w_clear  = bus.key_valid && (bus.key_code == 5'd20);
  assign w_neg    = bus.key_valid && (bus.key_code == 5'd21);
  assign w_room   = 32'(r_count) < MAX_DIGITS;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_A;
      r_entry  <= '0;
      r_acc    <= '0;
      r_opcode <= '0;
      r_count  <= '0;
      r_newop  <= 1'b0;
      r_newhex <= 1'b0;
      r_eq     <= 1'b0;
`ifdef CALC_CHAIN_EN
      r_pend   <= '0;
      r_chain  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state;
      r_entry  <= w_entry;
      r_acc    <= w_acc;
      r_opcode <= w_opcode;
      r_count  <= w_count;
      r_newop  <= w_newop;
      r_newhex <= w_newhex;
      r_eq     <= w_eq;
`ifdef CALC_CHAIN_EN
      r_pend   <= w_pend;
      r_chain  <= w_chain;
`endif
    end
  end

  // Operator key codes 16/17/18 map directly onto opcode via key_code[1:0].
  always_comb begin
    w_state  = r_state;
    w_entry  = r_entry;
    w_acc    = r_acc;
    w_opcode = r_opcode;
    w_count  = r_count;
    w_newop  = 1'b0;
    w_newhex = 1'b0;
    w_eq     = 1'b0;
`ifdef CALC_CHAIN_EN
    w_pend   = r_pend;
    w_chain  = r_chain;
`endif
    if (w_clear) begin
      // Clear wins in every state, including over the S_EVAL capture.
      w_state  = S_A;
      w_entry  = '0;
      w_acc    = '0;
      w_opcode = '0;
      w_count  = '0;
      w_newop  = 1'b1;
    end else begin
      case (r_state)
        S_A, S_B: begin
          if (w_digit && w_room) begin
            w_entry  = {r_entry[16], r_entry[11:0], bus.key_code[3:0]};
            w_count  = r_count + CW'(1);
            w_newhex = 1'b1;
          end else if (w_neg && (r_entry[15:0] != '0)) begin
            w_entry[16] = ~r_entry[16];
            w_newhex    = 1'b1;
          end else if ((r_state == S_A) && w_oper) begin
            w_acc    = r_entry;
            w_opcode = bus.key_code[1:0];
            w_entry  = '0;
            w_count  = '0;
            w_newop  = 1'b1;
            w_state  = S_OP;
          end else if ((r_state == S_B) && w_equals) begin
            w_eq    = 1'b1;
            w_state = S_EVAL;
`ifdef CALC_CHAIN_EN
            w_chain = 1'b0;
          end else if ((r_state == S_B) && w_oper) begin
            w_eq    = 1'b1;
            w_state = S_EVAL;
            w_pend  = bus.key_code[1:0];
            w_chain = 1'b1;
`endif
          end
        end
        S_OP: begin
          if (w_digit) begin
            w_entry  = {13'd0, bus.key_code[3:0]};
            w_count  = CW'(1);
            w_newhex = 1'b1;
            w_state  = S_B;
          end else if (w_oper) begin
            w_opcode = bus.key_code[1:0];
            w_newop  = 1'b1;
          end
        end
        S_EVAL: begin
          if (bus.ovw_in) begin
            w_state = S_ERR;
          end else begin
            w_acc   = bus.answer;
            w_entry = '0;
            w_count = '0;
            w_state = S_RES;
`ifdef CALC_CHAIN_EN
            if (r_chain) begin
              w_opcode = r_pend;
              w_newop  = 1'b1;
              w_state  = S_OP;
            end
`endif
          end
        end
        S_RES: begin
          if (w_digit) begin
            w_entry  = {13'd0, bus.key_code[3:0]};
            w_count  = CW'(1);
            w_newhex = 1'b1;
            w_state  = S_A;
          end else if (w_oper) begin
            w_opcode = bus.key_code[1:0];
            w_newop  = 1'b1;
            w_state  = S_OP;
          end
        end
        S_ERR: ;
        default: w_state = S_A;
      endcase
    end
  end

  always_comb begin
    case (r_state)
      S_A, S_B:            bus.disp = r_entry;
      S_OP, S_RES, S_EVAL: bus.disp = r_acc;
      default:             bus.disp = '0;
    endcase
  end

  assign bus.key_ready = (r_state != S_EVAL);
  assign bus.err       = (r_state == S_ERR);
  assign bus.V1        = r_entry;
  assign bus.V2        = r_acc;
  assign bus.opcode    = r_opcode;
  assign bus.newop     = r_newop;
  assign bus.newhex    = r_newhex;
  assign bus.eq        = r_eq;
endmodule

// File: tb/tb_calc_controller.sv
// tb_calc_controller: directed self-checking bench for calc_controller.
// Includes a behavioural sign-magnitude arithmetic unit; overflow is forced
// by the bench through force_ovw.
module tb_calc_controller;
  logic clock;
  logic reset;
  logic force_ovw;
  int   n_checks, n_fail;
  int   n_newop, n_newhex, n_eq, n_multi;
  int   a_val, b_val, r_val, r_mag;

  calc_controller_if bus ();

  calc_controller #(.MAX_DIGITS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Arithmetic unit: answer = acc (V2) op entry (V1).
  always_comb begin
    a_val = {16'd0, bus.V2[15:0]};
    if (bus.V2[16]) a_val = -a_val;
    b_val = {16'd0, bus.V1[15:0]};
    if (bus.V1[16]) b_val = -b_val;
    case (bus.opcode)
      2'b00:   r_val = a_val + b_val;
      2'b01:   r_val = a_val * b_val;
      2'b10:   r_val = a_val - b_val;
      default: r_val = 0;
    endcase
    r_mag      = (r_val < 0) ? -r_val : r_val;
    bus.answer = {(r_val < 0), r_mag[15:0]};
    bus.ovw_in = force_ovw;
  end

  always @(negedge clock) begin
    n_newop  += int'(bus.newop);
    n_newhex += int'(bus.newhex);
    n_eq     += int'(bus.eq);
    if ((int'(bus.newop) + int'(bus.newhex) + int'(bus.eq)) > 1) n_multi++;
  end

  task automatic press(input logic [4:0] code);
    @(negedge clock);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(posedge clock);
    #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  task automatic zero_counts();
    @(negedge clock);
    n_newop = 0; n_newhex = 0; n_eq = 0;
  endtask

  task automatic test_reset();
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    force_ovw     = 1'b0;
    reset         = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (bus.disp !== 17'h0) begin n_fail++; $display("FAIL reset_disp: got %h expected 00000", bus.disp); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    n_checks++; if (bus.key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_key_ready: got %b expected 1", bus.key_ready); end
    n_checks++; if ({bus.newop, bus.newhex, bus.eq} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {bus.newop, bus.newhex, bus.eq}); end
    n_checks++; if ({bus.V1, bus.V2, bus.opcode} !== 36'h0) begin n_fail++; $display("FAIL reset_regs: got V1=%h V2=%h op=%b expected zeros", bus.V1, bus.V2, bus.opcode); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_add();
    zero_counts();
    press(5'd1); press(5'd2); press(5'd16); press(5'd3); press(5'd4); press(5'd19);
    n_checks++; if (bus.key_ready !== 1'b0) begin n_fail++; $display("FAIL eval_key_ready: got %b expected 0", bus.key_ready); end
    settle();
    n_checks++; if (n_eq !== 1) begin n_fail++; $display("FAIL add_eq_count: got %0d expected 1", n_eq); end
    n_checks++; if (bus.disp !== 17'h00046) begin n_fail++; $display("FAIL add_disp: got %h expected 00046", bus.disp); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL add_err: got %b expected 0", bus.err); end
    // From the result state a digit starts a fresh entry shown on disp.
    press(5'd9);
    n_checks++; if (bus.disp !== 17'h00009) begin n_fail++; $display("FAIL res_digit_disp: got %h expected 00009", bus.disp); end
    n_checks++; if (bus.V2 !== 17'h00046) begin n_fail++; $display("FAIL res_acc_kept: got %h expected 00046", bus.V2); end
  endtask

  task automatic test_sub();
    press(5'd20);
    press(5'd5); press(5'd18); press(5'd7); press(5'd19);
    settle();
    n_checks++; if (bus.disp !== 17'h10002) begin n_fail++; $display("FAIL sub_disp: got %h expected 10002", bus.disp); end
  endtask

  task automatic test_overflow();
    press(5'd20);
    press(5'd15); press(5'd15); press(5'd15); press(5'd15); press(5'd16); press(5'd1);
    force_ovw = 1'b1;
    press(5'd19);
    settle();
    force_ovw = 1'b0;
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL ovw_err: got %b expected 1", bus.err); end
    n_checks++; if (bus.disp !== 17'h0) begin n_fail++; $display("FAIL ovw_disp: got %h expected 00000", bus.disp); end
    n_checks++; if (bus.V2 !== 17'h0FFFF) begin n_fail++; $display("FAIL ovw_acc_kept: got %h expected 0ffff", bus.V2); end
    zero_counts();
    press(5'd3); press(5'd19);
    settle();
    n_checks++; if (n_newhex !== 0 || bus.err !== 1'b1) begin n_fail++; $display("FAIL err_lock: got newhex=%0d err=%b expected 0 and 1", n_newhex, bus.err); end
    press(5'd20);
    n_checks++; if (bus.newop !== 1'b1) begin n_fail++; $display("FAIL err_clear_newop: got %b expected 1", bus.newop); end
    n_checks++; if (bus.err !== 1'b0 || bus.disp !== 17'h0) begin n_fail++; $display("FAIL err_clear: got err=%b disp=%h expected 0 and 00000", bus.err, bus.disp); end
  endtask

  task automatic test_digit_limit();
    press(5'd20);
    zero_counts();
    press(5'd1); press(5'd2); press(5'd3); press(5'd4); press(5'd5);
    settle();
    n_checks++; if (bus.V1 !== 17'h01234) begin n_fail++; $display("FAIL limit_entry: got %h expected 01234", bus.V1); end
    n_checks++; if (n_newhex !== 4) begin n_fail++; $display("FAIL limit_newhex: got %0d expected 4", n_newhex); end
  endtask

  task automatic test_negate();
    press(5'd20);
    zero_counts();
    press(5'd21);
    settle();
    n_checks++; if (bus.V1 !== 17'h0 || n_newhex !== 0) begin n_fail++; $display("FAIL neg_zero: got V1=%h newhex=%0d expected 00000 and 0", bus.V1, n_newhex); end
    press(5'd3); press(5'd21);
    n_checks++; if (bus.V1 !== 17'h10003) begin n_fail++; $display("FAIL neg_set: got %h expected 10003", bus.V1); end
    press(5'd21);
    settle();
    n_checks++; if (bus.V1 !== 17'h00003 || n_newhex !== 3) begin n_fail++; $display("FAIL neg_toggle: got V1=%h newhex=%0d expected 00003 and 3", bus.V1, n_newhex); end
  endtask

  task automatic test_chain();
    press(5'd20);
    press(5'd2); press(5'd16); press(5'd3); press(5'd17);
    settle();
`ifdef CALC_CHAIN_EN
    n_checks++; if (bus.newop !== 1'b1 || bus.opcode !== 2'b01) begin n_fail++; $display("FAIL chain_newop: got newop=%b op=%b expected 1 and 01", bus.newop, bus.opcode); end
`else
    n_checks++; if (bus.opcode !== 2'b00 || bus.V1 !== 17'h00003) begin n_fail++; $display("FAIL chain_ignored: got op=%b V1=%h expected 00 and 00003", bus.opcode, bus.V1); end
`endif
    press(5'd4); press(5'd19);
    settle();
`ifdef CALC_CHAIN_EN
    n_checks++; if (bus.disp !== 17'h00014) begin n_fail++; $display("FAIL chain_disp: got %h expected 00014", bus.disp); end
`else
    n_checks++; if (bus.disp !== 17'h00036) begin n_fail++; $display("FAIL chain_disp: got %h expected 00036", bus.disp); end
`endif
  endtask

  task automatic test_clear_in_eval();
    press(5'd20);
    press(5'd1); press(5'd16); press(5'd2); press(5'd19);
    press(5'd20);
    n_checks++; if (bus.V2 !== 17'h0 || bus.disp !== 17'h0) begin n_fail++; $display("FAIL eval_clear_acc: got V2=%h disp=%h expected 00000", bus.V2, bus.disp); end
    n_checks++; if (bus.newop !== 1'b1 || bus.key_ready !== 1'b1) begin n_fail++; $display("FAIL eval_clear_newop: got newop=%b ready=%b expected 1 and 1", bus.newop, bus.key_ready); end
  endtask

  task automatic test_reset_in_eval();
    press(5'd7); press(5'd16); press(5'd2); press(5'd19);
    @(negedge clock);
    reset = 1'b1;
    settle();
    n_checks++; if (bus.V2 !== 17'h0 || bus.disp !== 17'h0) begin n_fail++; $display("FAIL eval_reset_acc: got V2=%h disp=%h expected 00000", bus.V2, bus.disp); end
    n_checks++; if ({bus.newop, bus.newhex, bus.eq} !== 3'b000 || bus.key_ready !== 1'b1) begin n_fail++; $display("FAIL eval_reset_pulses: got %b ready=%b expected 000 and 1", {bus.newop, bus.newhex, bus.eq}, bus.key_ready); end
    @(negedge clock);
    reset = 1'b0;
    press(5'd6);
    n_checks++; if (bus.disp !== 17'h00006) begin n_fail++; $display("FAIL post_reset_entry: got %h expected 00006", bus.disp); end
  endtask

  task automatic test_exclusive_pulses();
    settle();
    n_checks++; if (n_multi !== 0) begin n_fail++; $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", n_multi); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    n_newop = 0; n_newhex = 0; n_eq = 0; n_multi = 0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_digit_limit();
    test_negate();
    test_chain();
    test_clear_in_eval();
    test_reset_in_eval();
    test_exclusive_pulses();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
